// File: rtl/dma_reader.sv
// AXI3 read master: fetches a contiguous block of 64-bit words from DDR
// over HP0 and delivers them in order on a first-word fall-through stream.
module dma_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   aclk,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [31:0]            base_addr_i,
    input  logic [COUNT_WIDTH-1:0] num_words_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [31:0]            m_axi_araddr,
    output logic [3:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    localparam int LEN_W  = $clog2(BURST_LEN) + 1;
    localparam int OFF_W  = $clog2(BURST_LEN);
    localparam int SIZE_B = $clog2(DATA_WIDTH / 8);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [31:0]             r_addr;
    logic [COUNT_WIDTH-1:0]  r_remaining;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_beat;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_arvalid;
    logic [31:0]             r_araddr;
    logic [3:0]              r_arlen;

    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_count;

    logic [LEN_W-1:0]        w_room;
    logic [LEN_W-1:0]        w_len;
    logic [CNT_W-1:0]        w_free;
    logic                    w_credit;
    logic                    w_ar_fire;
    logic                    w_beat_fire;
    logic [LEN_W-1:0]        w_beat_next;
    logic                    w_last_beat;
    logic [COUNT_WIDTH-1:0]  w_rem_next;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rready;

    // Bursts stop at the next BURST_LEN*8-byte boundary, never crossing 4 KB
    assign w_room = LEN_W'(BURST_LEN) - {1'b0, r_addr[OFF_W+SIZE_B-1:SIZE_B]};

    always_comb begin
        w_len = w_room;
        if (r_remaining < COUNT_WIDTH'(w_room))
            w_len = r_remaining[LEN_W-1:0];
    end

    assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_credit    = (w_free >= CNT_W'(w_len));
    assign w_ar_fire   = r_arvalid & m_axi_arready;
    assign w_beat_fire = (r_state == S_DATA) & m_axi_rvalid;
    assign w_beat_next = r_beat + LEN_W'(1);
    assign w_last_beat = w_beat_fire & (w_beat_next == r_len);
    assign w_rem_next  = r_remaining - COUNT_WIDTH'(r_len);
    assign w_accept    = (r_state == S_IDLE) & start_i;
    assign w_push      = w_beat_fire;
    assign w_pop       = (r_count != '0) & ready_i;

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_next = (num_words_i == '0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                if (w_ar_fire)
                    w_next = S_DATA;
            end
            S_DATA: begin
                if (w_last_beat)
                    w_next = (w_rem_next != '0) ? S_ADDR : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_count == '0)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rready = 1'b0;
        if (r_state == S_DATA)
            w_rready = 1'b1;
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_addr      <= base_addr_i & ~32'h7;
                r_remaining <= num_words_i;
                r_error     <= 1'b0;
                r_busy      <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (r_state == S_ADDR && !r_arvalid && w_credit) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_addr;
                r_arlen   <= 4'(w_len - LEN_W'(1));
                r_len     <= w_len;
                r_beat    <= '0;
            end else if (w_ar_fire) begin
                r_arvalid <= 1'b0;
            end
            // The beat counter decides the burst end; rlast is only checked
            if (w_beat_fire) begin
                r_beat <= w_beat_next;
                if ((m_axi_rlast != (w_beat_next == r_len)) ||
                    (m_axi_rresp != 2'b00))
                    r_error <= 1'b1;
                if (w_beat_next == r_len) begin
                    r_addr      <= r_addr + (32'(r_len) << SIZE_B);
                    r_remaining <= w_rem_next;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push)
            r_mem[r_wptr] <= m_axi_rdata;
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign error_o       = r_error;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(SIZE_B);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = w_rready;
    assign valid_o       = (r_count != '0);
    assign data_o        = (r_count != '0) ? r_mem[r_rptr] : '0;

endmodule

// File: doc/dma_reader.md
Name: dma_reader

Overview:
AXI3 read master for the HP0 read channel. Fetches a contiguous block of 64-bit words from DDR and hands them out in order on a valid/ready stream, for example for DAC waveform playback or reloading a buffer. It is the read-direction counterpart of dma_controller, which writes to DDR over the same HP0 port. It runs on the fclk0 domain, and its AXI outputs drive the S_AXI_HP0_EXT_ar*/r* ports that are tied off today.

Parameters:
DATA_WIDTH, 64, AXI data and stream width; fixed at 64, and arsize is derived from it.
BURST_LEN, 16, maximum beats per burst; must be ≤16 (AXI3) and a power of 2.
FIFO_DEPTH, 32, output FIFO depth in words; must be a power of 2 and ≥ BURST_LEN.
COUNT_WIDTH, 20, width of the word-count input.

Ports:
aclk  in  1  clock (fclk0)
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  single-cycle request pulse; sampled only when idle
base_addr_i  in  32  byte address of the first word; bits [2:0] are ignored and treated as 0
num_words_i  in  COUNT_WIDTH  number of 64-bit words to fetch
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse when the transfer is complete
error_o  out  1  sticky protocol/response error; cleared by the next accepted start
m_axi_araddr  out  32  burst address
m_axi_arlen  out  4  beats minus 1
m_axi_arsize  out  3  fixed 3'b011
m_axi_arburst  out  2  fixed 2'b01 (INCR)
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  64  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
data_o  out  64  stream data
valid_o  out  1  stream valid
ready_i  in  1  stream ready

Behaviour:
- Reset values: arvalid=0, rready=0, araddr=0, arlen=0, busy_o=0, done_o=0, error_o=0, valid_o=0, data_o=0. The FIFO is emptied and the FSM is in IDLE. Reset is asynchronous and takes effect immediately, including mid-burst. No draining of an outstanding burst is attempted; the shared interconnect reset covers it.
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE: start_i=1 latches the address and count, clears error_o and sets busy_o next cycle.
  - If num_words=0, go to DONE.
  - Otherwise go to ADDR.
  - start_i is ignored in every other state.
- ADDR: burst length len = min(remaining, BURST_LEN − addr[6:3]), so that no burst crosses a BURST_LEN·8-byte boundary and therefore never crosses a 4 KB boundary.
  - arvalid rises only when FIFO free space ≥ len, i.e. FIFO_DEPTH − count ≥ len. This credit rule is what allows rready to be held at 1 for the whole DATA state.
  - araddr and arlen are stable while arvalid=1 and arready=0.
  - On arvalid&arready, go to DATA.
  - Address latency: start_i at cycle 0 gives the earliest arvalid at cycle 2.
- DATA: rready=1. Each rvalid beat is pushed into the FIFO. Exactly one burst is outstanding.
  - The beat counter is authoritative. When it reaches len: address += len·8, remaining −= len, and the next state is ADDR if remaining>0, else DRAIN.
  - rlast asserted on a beat other than the last, or deasserted on the last beat, sets error_o. Data is still pushed and the counter still governs.
  - rresp≠2'b00 sets error_o. Data is still pushed.
- DRAIN: wait until the FIFO is empty and no pop is pending, then go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o falls on the same edge, then return to IDLE.
- FIFO: first-word fall-through.
  - valid_o = !empty; data_o = head entry.
  - A beat accepted at edge k is visible on the stream at k+1.
  - A pop happens on valid_o&ready_i.
  - A simultaneous push and pop leaves the count unchanged.
  - Overflow cannot occur by construction; the bench asserts this.
  - Full with a pop pending still accepts the push.
- Address and remaining count are modular in their widths. Wrap past 0xFFFF_FFFF is not checked.

Test Plan:
1. base=0x1000_0000, num=40, arready=1, rvalid every cycle with correct rlast, ready_i=1 -> bursts arlen=15/15/7 at 0x1000_0000/0x1000_0080/0x1000_0100; 40 words out in order; one done_o pulse; busy_o falls with it; error_o=0.
2. base=0x1000_0068, num=5 -> burst arlen=2 at 0x1000_0068, then arlen=1 at 0x1000_0080; 5 words out in order.
3. FIFO_DEPTH=32, num=64, ready_i=0 -> exactly two ARs issued; no third arvalid until 16 words are popped; then ready_i=1 -> all 64 words delivered in order with no loss.
4. num=20, rresp=2'b10 on beat 3, plus rlast asserted early on beat 9 of the first burst -> error_o=1 and stays high through done_o; all 20 words delivered; next start clears error_o.
5. num=0 -> no arvalid; done_o two cycles after start_i; start_i pulsed while busy on another run -> ignored, with no second done_o.
6. rst_i asserted mid-DATA -> arvalid/rready/valid_o/busy_o go to 0 immediately and the FIFO is empty; after release, base=0x2000_0000, num=16 -> a single arlen=15 burst completes normally.
